pwm_capture: RTL and testbench

Measures a single-ended PWM/pulse train and reports period and high time in clock cycles. It is the receive-side counterpart of the team's `timer` PWM generator. It sits in the peripheral subsystem: a pin or an on-chip PWM source feeds `pwm_in`, and software or monitoring logic reads the latched measurements on each `meas_valid` strobe. A timeout path flags a dead or stuck input (0 %/100 % duty).

---
 rtl/pwm_capture_pkg.sv | 20 ++
 rtl/pwm_edge_sync.sv | 33 +++
 rtl/pwm_capture.sv | 158 +++++++++++++++
 tb/tb_pwm_capture.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/pwm_capture_pkg.sv
// Shared types and constants for the PWM period/high-time capture block.
// Imported by the RTL and by the testbench.
package pwm_capture_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        RUN   = 2'd2
    } state_t;

    localparam int CNT_W_DEFAULT = 16;
    localparam int SYNC_STAGES   = 2;

    // TIMEOUT must fit the counter and leave room for at least one counted cycle.
    function automatic bit timeout_legal(input int timeout_cycles, input int cnt_w);
        return (timeout_cycles >= 2) &&
               (longint'(timeout_cycles) <= ((longint'(1) << cnt_w) - 1));
    endfunction

endpackage

// File: rtl/pwm_edge_sync.sv
// Multi-flop synchronizer for an asynchronous pin plus a delay flop,
// giving the synchronized level and one-cycle rise/fall pulses.
module pwm_edge_sync
    import pwm_capture_pkg::*;
#(
    parameter int STAGES = SYNC_STAGES
) (
    input  logic clk,
    input  logic rst_n,
    input  logic sig,
    output logic s,
    output logic rise,
    output logic fall
);

    logic [STAGES-1:0] sync_reg;
    logic              s_d_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_reg <= '0;
            s_d_reg  <= 1'b0;
        end else begin
            sync_reg <= {sync_reg[STAGES-2:0], sig};
            s_d_reg  <= sync_reg[STAGES-1];
        end
    end

    assign s    = sync_reg[STAGES-1];
    assign rise = s & ~s_d_reg;
    assign fall = ~s & s_d_reg;

endmodule

// File: rtl/pwm_capture.sv
// Measures period and high time of a PWM input in clk cycles, with a
// timeout strobe that flags a dead or stuck (0 %/100 % duty) input.
module pwm_capture
    import pwm_capture_pkg::*;
#(
    parameter int CNT_W   = CNT_W_DEFAULT,
    parameter int TIMEOUT = 65535
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable,
    input  logic             pwm_in,
    output logic             meas_valid,
    output logic [CNT_W-1:0] period_cnt,
    output logic [CNT_W-1:0] high_cnt,
    output logic             timeout,
    output logic             level
);

    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT);

    if (!timeout_legal(TIMEOUT, CNT_W)) begin : g_bad_timeout
        $error("pwm_capture: TIMEOUT must lie in 2 .. 2**CNT_W-1");
    end

    logic s;
    logic rise;
    logic fall;

    pwm_edge_sync #(
        .STAGES(SYNC_STAGES)
    ) u_sync (
        .clk  (clk),
        .rst_n(rst_n),
        .sig  (pwm_in),
        .s    (s),
        .rise (rise),
        .fall (fall)
    );

    state_t           state_reg;
    state_t           state_next;
    logic [CNT_W-1:0] cnt_reg;
    logic [CNT_W-1:0] high_lat_reg;
    logic [CNT_W-1:0] period_reg;
    logic [CNT_W-1:0] high_reg;
    logic             meas_valid_reg;
    logic             timeout_reg;
    logic             level_reg;

    logic at_limit;
    logic cnt_clear;
    logic cnt_load;
    logic cnt_inc;
    logic hl_clear;
    logic hl_load;
    logic meas_load;
    logic to_fire;

    // cnt never passes CNT_LIMIT: the timeout clears it first.
    assign at_limit = (cnt_reg == CNT_LIMIT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        if (!enable) begin
            state_next = IDLE;
        end else begin
            case (state_reg)
                IDLE:  if (rise) state_next = ARMED;
                ARMED: begin
                    if (rise)          state_next = RUN;
                    else if (at_limit) state_next = IDLE;
                end
                RUN: begin
                    if (rise)          state_next = RUN;
                    else if (at_limit) state_next = IDLE;
                end
                default: state_next = IDLE;
            endcase
        end
    end

    // A rise takes priority over the timeout; enable low overrides everything.
    always_comb begin
        cnt_clear = 1'b0;
        cnt_load  = 1'b0;
        cnt_inc   = 1'b0;
        hl_clear  = 1'b0;
        hl_load   = 1'b0;
        meas_load = 1'b0;
        to_fire   = 1'b0;
        if (!enable) begin
            cnt_clear = 1'b1;
            hl_clear  = 1'b1;
        end else begin
            case (state_reg)
                IDLE: cnt_load = rise;
                ARMED, RUN: begin
                    if (rise) begin
                        cnt_load  = 1'b1;
                        meas_load = (state_reg == RUN);
                    end else if (at_limit) begin
                        to_fire   = 1'b1;
                        cnt_clear = 1'b1;
                    end else begin
                        cnt_inc   = 1'b1;
                    end
                    hl_load = fall;
                end
                default: cnt_clear = 1'b1;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_reg        <= '0;
            high_lat_reg   <= '0;
            period_reg     <= '0;
            high_reg       <= '0;
            meas_valid_reg <= 1'b0;
            timeout_reg    <= 1'b0;
            level_reg      <= 1'b0;
        end else begin
            if (cnt_clear)     cnt_reg <= '0;
            else if (cnt_load) cnt_reg <= CNT_ONE;
            else if (cnt_inc)  cnt_reg <= cnt_reg + CNT_ONE;

            if (hl_clear)     high_lat_reg <= '0;
            else if (hl_load) high_lat_reg <= cnt_reg;

            meas_valid_reg <= meas_load;
            if (meas_load) begin
                period_reg <= cnt_reg;
                high_reg   <= high_lat_reg;
            end

            timeout_reg <= to_fire;
            if (to_fire) level_reg <= s;
        end
    end

    assign meas_valid = meas_valid_reg;
    assign period_cnt = period_reg;
    assign high_cnt   = high_reg;
    assign timeout    = timeout_reg;
    assign level      = level_reg;

endmodule

// File: tb/tb_pwm_capture.sv
// Directed testbench for pwm_capture: table of steady waveforms plus
// hand-written timeout, enable-abort and async-reset sequences.
module tb_pwm_capture;
    import pwm_capture_pkg::*;

    localparam int W  = CNT_W_DEFAULT;
    localparam int TO = 50;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         enable;
    logic         pwm_in;
    logic         meas_valid;
    logic [W-1:0] period_cnt;
    logic [W-1:0] high_cnt;
    logic         timeout;
    logic         level;

    pwm_capture #(
        .CNT_W  (W),
        .TIMEOUT(TO)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .enable    (enable),
        .pwm_in    (pwm_in),
        .meas_valid(meas_valid),
        .period_cnt(period_cnt),
        .high_cnt  (high_cnt),
        .timeout   (timeout),
        .level     (level)
    );

    always #5 clk = ~clk;

    typedef struct {int cyc; int period; int high;} meas_t;
    typedef struct {int cyc; int lvl;} to_t;
    typedef struct {
        int period; int high; int n_rises;
        int exp_period; int exp_high; int exp_strobes;
    } vec_t;

    meas_t mv_q[$];
    to_t   to_q[$];
    int    rise_q[$];
    int    cyc     = 0;
    int    phase   = 0;
    int    n_tests = 0;
    int    n_fail  = 0;
    vec_t  vecs[6];

    // Strobe monitor: samples 1 ns after each rising edge.
    initial forever begin
        @(posedge clk);
        cyc++;
        #1;
        if (meas_valid) mv_q.push_back('{cyc, int'(period_cnt), int'(high_cnt)});
        if (timeout)    to_q.push_back('{cyc, int'(level)});
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not finish, got timeout required finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d required %0d", name, act, exp);
        end
    endtask

    // Drives n cycles of a p-cycle waveform high for h cycles, recording rises.
    task automatic run_wave(input int p, input int h, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (phase == 0 && h > 0) rise_q.push_back(cyc);
            pwm_in = (phase < h);
            phase  = (phase + 1) % p;
        end
    endtask

    task automatic hold(input logic v, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            pwm_in = v;
        end
    endtask

    task automatic start_run();
        mv_q.delete();
        to_q.delete();
        rise_q.delete();
        phase  = 0;
        enable = 1'b1;
    endtask

    task automatic stop_run();
        enable = 1'b0;
        hold(1'b0, 5);
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        start_run();
        run_wave(v.period, v.high, (v.n_rises - 1) * v.period + 1);
        hold(1'b1, 4);
        check({tag, "_strobes"}, mv_q.size(), v.exp_strobes);
        check({tag, "_timeouts"}, to_q.size(), 0);
        for (int i = 0; i < mv_q.size() && i < v.exp_strobes; i++) begin
            check($sformatf("%s_period%0d", tag, i), mv_q[i].period, v.exp_period);
            check($sformatf("%s_high%0d", tag, i), mv_q[i].high, v.exp_high);
            check($sformatf("%s_cycle%0d", tag, i), mv_q[i].cyc, rise_q[i + 2] + 3);
        end
        stop_run();
    endtask

    task automatic run_timeout(input logic held, input string tag);
        int d;
        start_run();
        run_wave(10, 5, 31);
        d = rise_q[3];
        if (held) begin
            hold(1'b1, 70);
        end else begin
            hold(1'b1, 4);
            hold(1'b0, 66);
        end
        check({tag, "_count"}, to_q.size(), 1);
        if (to_q.size() >= 1) begin
            check({tag, "_cycle"}, to_q[0].cyc, d + 3 + TO);
            check({tag, "_level"}, to_q[0].lvl, int'(held));
        end
        check({tag, "_strobes"}, mv_q.size(), 2);
        check({tag, "_held_period"}, int'(period_cnt), 10);
        check({tag, "_held_high"}, int'(high_cnt), 5);
        stop_run();
    endtask

    initial begin
        vecs[0] = '{10, 5, 5, 10, 5, 3};
        vecs[1] = '{20, 6, 4, 20, 6, 2};
        vecs[2] = '{49, 20, 4, 49, 20, 2};
        vecs[3] = '{50, 25, 4, 50, 25, 2};
        vecs[4] = '{2, 1, 6, 2, 1, 4};
        vecs[5] = '{3, 2, 5, 3, 2, 3};

        rst_n  = 1'b0;
        enable = 1'b0;
        pwm_in = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_meas_valid", int'(meas_valid), 0);
        check("reset_timeout", int'(timeout), 0);
        check("reset_period", int'(period_cnt), 0);
        check("reset_high", int'(high_cnt), 0);
        check("reset_level", int'(level), 0);
        rst_n = 1'b1;
        hold(1'b0, 2);

        for (int i = 0; i < 6; i++) begin
            run_vec(vecs[i], $sformatf("vec%0d_p%0d", i, vecs[i].period));
            $display("[TB] vector %0d: period %0d high %0d, %0d strobes seen",
                     i, vecs[i].period, vecs[i].high, mv_q.size());
        end

        run_timeout(1'b1, "timeout_high");
        $display("[TB] timeout with input held high, %0d timeout strobes", to_q.size());
        run_timeout(1'b0, "timeout_low");
        $display("[TB] timeout with input held low, %0d timeout strobes", to_q.size());
        run_timeout(1'b1, "timeout_high2");
        $display("[TB] timeout with input held high again, level now %0d", level);

        // Asynchronous reset in the middle of a period, away from any clock edge.
        start_run();
        run_wave(10, 5, 35);
        check("prereset_period", int'(period_cnt), 10);
        check("prereset_level", int'(level), 1);
        #2;
        rst_n  = 1'b0;
        pwm_in = 1'b0;
        #1;
        check("async_reset_meas_valid", int'(meas_valid), 0);
        check("async_reset_timeout", int'(timeout), 0);
        check("async_reset_period", int'(period_cnt), 0);
        check("async_reset_high", int'(high_cnt), 0);
        check("async_reset_level", int'(level), 0);
        $display("[TB] async reset mid-period, period_cnt now %0d", period_cnt);
        enable = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        hold(1'b0, 2);
        run_vec(vecs[0], "post_reset");
        $display("[TB] post-reset run, %0d strobes seen", mv_q.size());

        // Enable dropped for 7 cycles in the middle of a period.
        start_run();
        run_wave(10, 5, 45);
        check("en_before_strobes", mv_q.size(), 3);
        enable = 1'b0;
        run_wave(10, 5, 7);
        check("en_off_strobes", mv_q.size(), 3);
        check("en_off_held_period", int'(period_cnt), 10);
        check("en_off_held_high", int'(high_cnt), 5);
        enable = 1'b1;
        run_wave(10, 5, 21);
        hold(1'b1, 4);
        check("en_after_strobes", mv_q.size(), 4);
        check("en_after_timeouts", to_q.size(), 0);
        if (mv_q.size() >= 4) begin
            check("en_after_cycle", mv_q[3].cyc, rise_q[7] + 3);
            check("en_after_period", mv_q[3].period, 10);
            check("en_after_high", mv_q[3].high, 5);
        end
        $display("[TB] enable abort sequence, %0d strobes seen", mv_q.size());
        stop_run();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
